// File: rtl/oob_link_supervisor.sv
// rtl/oob_link_supervisor.sv - SATA OOB bring-up supervisor: retries with exponential backoff, speed fallback, link-loss tracking
module oob_link_supervisor #(
    parameter int NUM_GEN      = 3,
    parameter int MAX_RETRY    = 4,
    parameter int BACKOFF_BASE = 256,
    parameter int CNT_W        = 16,
    parameter int ERR_W        = 8,
    localparam int GEN_W = (NUM_GEN > 1) ? $clog2(NUM_GEN) : 1,
    localparam int RTY_W = $clog2(MAX_RETRY + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             gtx_ready,
    input  logic             set_offline,
    input  logic             comreset_send,
    input  logic             oob_busy,
    input  logic             link_up,
    input  logic             link_down,
    input  logic             oob_error,
    input  logic             oob_silence,
    input  logic             cominit_req,
    input  logic             rxbyteisaligned,
    input  logic             rate_ack,
    output logic             oob_start,
    output logic             cominit_allow,
    output logic             force_txelecidle,
    output logic             phy_ready,
    output logic [GEN_W-1:0] rate_req,
    output logic             rate_change,
    output logic [GEN_W-1:0] link_gen,
    output logic [RTY_W-1:0] retry_cnt,
    output logic [ERR_W-1:0] link_loss_cnt,
    output logic             link_fail,
    output logic [2:0]       state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_START   = 3'd1,
        S_WAIT    = 3'd2,
        S_UP      = 3'd3,
        S_BACKOFF = 3'd4,
        S_RATE    = 3'd5,
        S_OFFLINE = 3'd6,
        S_FAIL    = 3'd7
    } state_t;

    localparam int               BW       = CNT_W + 32;
    localparam logic [GEN_W-1:0] GEN_TOP  = GEN_W'(NUM_GEN - 1);
    localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRY);
    localparam logic [CNT_W-1:0] BO_MAX   = '1;
    localparam logic [ERR_W-1:0] LOSS_MAX = '1;

    state_t           state_q, state_d;
    logic [GEN_W-1:0] link_gen_q, link_gen_d;
    logic [GEN_W-1:0] rate_req_q, rate_req_d;
    logic [RTY_W-1:0] retry_q, retry_d;
    logic [ERR_W-1:0] loss_q, loss_d;
    logic [CNT_W-1:0] bo_cnt_q, bo_cnt_d;
    logic             oob_start_q, oob_start_d;
    logic             rate_change_q, rate_change_d;
    logic             txidle_q, txidle_d;
    logic             fail_q, fail_d;

    logic [RTY_W-1:0] retry_inc;
    logic [BW-1:0]    bo_wide;
    logic [CNT_W-1:0] bo_len;

    // Backoff for the failure being counted now: base << (new retry count - 1), i.e. shifted by the old count.
    always_comb begin
        retry_inc = retry_q + RTY_W'(1);
        bo_wide   = BW'(BACKOFF_BASE) << retry_q;
        if (int'(retry_q) >= CNT_W || bo_wide > BW'(BO_MAX)) begin
            bo_len = BO_MAX;
        end else begin
            bo_len = bo_wide[CNT_W-1:0];
        end
    end

    always_comb begin
        state_d    = state_q;
        link_gen_d = link_gen_q;
        rate_req_d = rate_req_q;
        retry_d    = retry_q;
        loss_d     = loss_q;
        bo_cnt_d   = bo_cnt_q;

        // A rate change in flight must complete, so RATE ignores every global control.
        if (state_q != S_RATE && comreset_send) begin
            retry_d = '0;
            if (link_gen_q != GEN_TOP) begin
                state_d    = S_RATE;
                rate_req_d = GEN_TOP;
            end else begin
                state_d = S_IDLE;
            end
        end else if (state_q != S_RATE && set_offline) begin
            state_d = S_OFFLINE;
        end else if (!gtx_ready && !(state_q inside {S_OFFLINE, S_FAIL, S_RATE})) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: if (!oob_busy) state_d = S_START;
                S_START: state_d = S_WAIT;
                S_WAIT: begin
                    if (link_up) begin
                        state_d = S_UP;
                        retry_d = '0;
                    end else if (oob_error || oob_silence) begin
                        retry_d = retry_inc;
                        if (retry_inc < RTY_MAX) begin
                            state_d  = S_BACKOFF;
                            bo_cnt_d = bo_len;
                        end else if (link_gen_q != '0) begin
                            state_d    = S_RATE;
                            rate_req_d = link_gen_q - GEN_W'(1);
                        end else begin
                            state_d = S_FAIL;
                        end
                    end
                end
                S_BACKOFF: begin
                    if (bo_cnt_q == '0) state_d = S_START;
                    else                bo_cnt_d = bo_cnt_q - CNT_W'(1);
                end
                S_RATE: begin
                    if (rate_ack) begin
                        link_gen_d = rate_req_q;
                        retry_d    = '0;
                        state_d    = S_IDLE;
                    end
                end
                S_UP: begin
                    if (link_down) begin
                        if (loss_q != LOSS_MAX) loss_d = loss_q + ERR_W'(1);
                        retry_d = '0;
                        state_d = S_START;
                    end else if (cominit_req) begin
                        state_d = S_WAIT;
                    end
                end
                default: ;
            endcase
        end

        oob_start_d   = (state_d == S_START);
        txidle_d      = (state_d == S_OFFLINE);
        fail_d        = (state_d == S_FAIL);
        rate_change_d = (state_d == S_RATE) && (state_q != S_RATE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            link_gen_q    <= GEN_TOP;
            rate_req_q    <= GEN_TOP;
            retry_q       <= '0;
            loss_q        <= '0;
            bo_cnt_q      <= '0;
            oob_start_q   <= 1'b0;
            rate_change_q <= 1'b0;
            txidle_q      <= 1'b0;
            fail_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            link_gen_q    <= link_gen_d;
            rate_req_q    <= rate_req_d;
            retry_q       <= retry_d;
            loss_q        <= loss_d;
            bo_cnt_q      <= bo_cnt_d;
            oob_start_q   <= oob_start_d;
            rate_change_q <= rate_change_d;
            txidle_q      <= txidle_d;
            fail_q        <= fail_d;
        end
    end

    assign oob_start        = oob_start_q;
    assign rate_change      = rate_change_q;
    assign force_txelecidle = txidle_q;
    assign link_fail        = fail_q;
    assign rate_req         = rate_req_q;
    assign link_gen         = link_gen_q;
    assign retry_cnt        = retry_q;
    assign link_loss_cnt    = loss_q;
    assign state_dbg        = state_q;
    assign phy_ready        = (state_q == S_UP) && gtx_ready && rxbyteisaligned;
    assign cominit_allow    = cominit_req && (state_q == S_UP);

endmodule

// File: tb/tb_oob_link_supervisor.sv
// tb/tb_oob_link_supervisor.sv - directed and randomized checks of oob_link_supervisor against a behavioural model
module tb_oob_link_supervisor;

    localparam int NG = 3, MR = 4, BB = 4, CW = 4, EW = 2;
    localparam int S_IDLE = 0, S_START = 1, S_WAIT = 2, S_UP = 3;
    localparam int S_BACKOFF = 4, S_RATE = 5, S_OFFLINE = 6, S_FAIL = 7;

    logic clk = 1'b0;
    logic rst_n;
    logic gtx_ready, set_offline, comreset_send, oob_busy, link_up, link_down;
    logic oob_error, oob_silence, cominit_req, rxbyteisaligned, rate_ack;
    logic oob_start, cominit_allow, force_txelecidle, phy_ready, rate_change, link_fail;
    logic [1:0] rate_req, link_gen;
    logic [2:0] retry_cnt, state_dbg;
    logic [EW-1:0] link_loss_cnt;

    always #5 clk = ~clk;

    oob_link_supervisor #(
        .NUM_GEN(NG), .MAX_RETRY(MR), .BACKOFF_BASE(BB), .CNT_W(CW), .ERR_W(EW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .gtx_ready(gtx_ready), .set_offline(set_offline),
        .comreset_send(comreset_send), .oob_busy(oob_busy), .link_up(link_up),
        .link_down(link_down), .oob_error(oob_error), .oob_silence(oob_silence),
        .cominit_req(cominit_req), .rxbyteisaligned(rxbyteisaligned), .rate_ack(rate_ack),
        .oob_start(oob_start), .cominit_allow(cominit_allow), .force_txelecidle(force_txelecidle),
        .phy_ready(phy_ready), .rate_req(rate_req), .rate_change(rate_change),
        .link_gen(link_gen), .retry_cnt(retry_cnt), .link_loss_cnt(link_loss_cnt),
        .link_fail(link_fail), .state_dbg(state_dbg)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Behavioural model: backoff is tracked as the absolute cycle on which START must begin.
    int ms, m_gen, m_req, m_retry, m_loss, m_start_at;
    bit m_rc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d cycle=%0d", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        ms = S_IDLE; m_gen = NG - 1; m_req = NG - 1; m_retry = 0; m_loss = 0; m_rc = 0; m_start_at = 0;
    endtask

    function automatic int backoff_len(input int failures);
        longint v;
        v = longint'(BB) * (longint'(1) << (failures - 1));
        if (v > (2 ** CW) - 1) v = (2 ** CW) - 1;
        return int'(v);
    endfunction

    task automatic model_clock();
        int ns;
        ns = ms;
        m_rc = 0;
        if (ms != S_RATE && comreset_send) begin
            m_retry = 0;
            if (m_gen != NG - 1) begin ns = S_RATE; m_req = NG - 1; m_rc = 1; end
            else ns = S_IDLE;
        end else if (ms != S_RATE && set_offline) begin
            ns = S_OFFLINE;
        end else if (!gtx_ready && ms != S_OFFLINE && ms != S_FAIL && ms != S_RATE) begin
            ns = S_IDLE;
        end else begin
            case (ms)
                S_IDLE:  if (!oob_busy) ns = S_START;
                S_START: ns = S_WAIT;
                S_WAIT: begin
                    if (link_up) begin ns = S_UP; m_retry = 0; end
                    else if (oob_error || oob_silence) begin
                        m_retry++;
                        if (m_retry < MR) begin
                            ns = S_BACKOFF;
                            m_start_at = cyc + backoff_len(m_retry) + 1;
                        end else if (m_gen > 0) begin
                            ns = S_RATE; m_req = m_gen - 1; m_rc = 1;
                        end else ns = S_FAIL;
                    end
                end
                S_BACKOFF: if (cyc == m_start_at) ns = S_START;
                S_RATE: if (rate_ack) begin m_gen = m_req; m_retry = 0; ns = S_IDLE; end
                S_UP: begin
                    if (link_down) begin
                        m_loss = (m_loss + 1 > (2 ** EW) - 1) ? (2 ** EW) - 1 : m_loss + 1;
                        m_retry = 0; ns = S_START;
                    end else if (cominit_req) ns = S_WAIT;
                end
                default: ;
            endcase
        end
        ms = ns;
    endtask

    task automatic compare_all();
        chk("state_dbg", state_dbg, ms);
        chk("oob_start", oob_start, ms == S_START);
        chk("force_txelecidle", force_txelecidle, ms == S_OFFLINE);
        chk("link_fail", link_fail, ms == S_FAIL);
        chk("rate_change", rate_change, m_rc);
        chk("rate_req", rate_req, m_req);
        chk("link_gen", link_gen, m_gen);
        chk("retry_cnt", retry_cnt, m_retry);
        chk("link_loss_cnt", link_loss_cnt, m_loss);
        chk("phy_ready", phy_ready, (ms == S_UP) && gtx_ready && rxbyteisaligned);
        chk("cominit_allow", cominit_allow, (ms == S_UP) && cominit_req);
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) model_clock(); else model_reset();
        cyc++;
        #1;
        compare_all();
    endtask

    task automatic clear_inputs();
        gtx_ready = 0; set_offline = 0; comreset_send = 0; oob_busy = 0; link_up = 0; link_down = 0;
        oob_error = 0; oob_silence = 0; cominit_req = 0; rxbyteisaligned = 0; rate_ack = 0;
    endtask

    task automatic do_reset();
        rst_n = 0;
        clear_inputs();
        model_reset();
        tick();
        tick();
        rst_n = 1;
    endtask

    task automatic wait_start(input int budget, output int n);
        n = 0;
        while (oob_start !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        chk("oob_start_reached", oob_start, 1);
    endtask

    task automatic fail_cycle();
        int n;
        wait_start(40, n);
        tick();
        oob_silence = 1;
        tick();
        oob_silence = 0;
    endtask

    typedef struct {
        logic gtx, busy, up, err, rxal;
        int   st, start, retry, phy;
    } vec_t;
    vec_t vt[14];

    int wn, starts;
    int bo_exp[3];

    initial begin
        #1_000_000;
        $display("FAIL watchdog_timeout actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0]  = '{0, 0, 0, 0, 0, S_IDLE,    0, 0, 0};
        vt[1]  = '{1, 1, 0, 0, 0, S_IDLE,    0, 0, 0};
        vt[2]  = '{1, 0, 0, 0, 0, S_START,   1, 0, 0};
        vt[3]  = '{1, 0, 0, 0, 0, S_WAIT,    0, 0, 0};
        vt[4]  = '{1, 0, 0, 1, 0, S_BACKOFF, 0, 1, 0};
        vt[5]  = '{1, 0, 0, 0, 0, S_BACKOFF, 0, 1, 0};
        vt[6]  = '{1, 0, 0, 0, 0, S_BACKOFF, 0, 1, 0};
        vt[7]  = '{1, 0, 0, 0, 0, S_BACKOFF, 0, 1, 0};
        vt[8]  = '{1, 0, 0, 0, 0, S_BACKOFF, 0, 1, 0};
        vt[9]  = '{1, 0, 0, 0, 0, S_START,   1, 1, 0};
        vt[10] = '{1, 0, 0, 0, 0, S_WAIT,    0, 1, 0};
        vt[11] = '{1, 0, 1, 0, 0, S_UP,      0, 0, 0};
        vt[12] = '{1, 0, 0, 0, 1, S_UP,      0, 0, 1};
        vt[13] = '{0, 0, 0, 0, 1, S_IDLE,    0, 0, 0};
        bo_exp[0] = 4; bo_exp[1] = 8; bo_exp[2] = 15;

        rst_n = 0;
        clear_inputs();
        model_reset();
        do_reset();

        for (int i = 0; i < 14; i++) begin
            gtx_ready = vt[i].gtx; oob_busy = vt[i].busy; link_up = vt[i].up;
            oob_error = vt[i].err; rxbyteisaligned = vt[i].rxal;
            tick();
            chk("vec_state", state_dbg, vt[i].st);
            chk("vec_oob_start", oob_start, vt[i].start);
            chk("vec_retry", retry_cnt, vt[i].retry);
            chk("vec_phy_ready", phy_ready, vt[i].phy);
        end

        // Backoff growth 4, 8, then saturated 15, then fallback to generation 1.
        do_reset();
        gtx_ready = 1;
        wait_start(10, wn);
        for (int k = 0; k < 3; k++) begin
            tick();
            oob_silence = 1; tick(); oob_silence = 0;
            chk("retry_after_fail", retry_cnt, k + 1);
            wait_start(40, wn);
            chk("backoff_ticks", wn, bo_exp[k] + 1);
        end
        tick();
        oob_silence = 1; tick(); oob_silence = 0;
        chk("fallback_state", state_dbg, S_RATE);
        chk("fallback_rate_change", rate_change, 1);
        chk("fallback_rate_req", rate_req, 1);
        tick();
        chk("rate_change_one_cycle", rate_change, 0);
        rate_ack = 1; tick(); rate_ack = 0;
        chk("after_ack_gen", link_gen, 1);
        chk("after_ack_state", state_dbg, S_IDLE);

        // Exhaust generations 1 and 0, then recover via COMRESET.
        for (int k = 0; k < MR; k++) fail_cycle();
        chk("gen0_rate_req", rate_req, 0);
        rate_ack = 1; tick(); rate_ack = 0;
        for (int k = 0; k < MR; k++) fail_cycle();
        chk("link_fail_set", link_fail, 1);
        starts = 0;
        for (int k = 0; k < 20; k++) begin tick(); if (oob_start === 1'b1) starts++; end
        chk("no_start_in_fail", starts, 0);
        comreset_send = 1; tick(); comreset_send = 0;
        chk("comreset_rate_req", rate_req, 2);
        chk("comreset_link_fail", link_fail, 0);
        rate_ack = 1; tick(); rate_ack = 0;
        chk("recover_gen", link_gen, 2);
        tick();
        chk("recover_start", oob_start, 1);

        // Link loss counting with saturation, no backoff on restart.
        do_reset();
        gtx_ready = 1; rxbyteisaligned = 1;
        wait_start(10, wn);
        tick(); link_up = 1; tick(); link_up = 0;
        chk("up_phy_ready", phy_ready, 1);
        for (int k = 1; k <= 5; k++) begin
            link_down = 1; tick(); link_down = 0;
            chk("loss_restart", oob_start, 1);
            chk("loss_cnt", link_loss_cnt, (k > 3) ? 3 : k);
            tick(); link_up = 1; tick(); link_up = 0;
        end
        cominit_req = 1; #1;
        chk("cominit_allow_up", cominit_allow, 1);
        tick(); cominit_req = 0;
        chk("cominit_to_wait", state_dbg, S_WAIT);

        // Asynchronous reset mid-operation.
        rst_n = 0; #1;
        chk("async_state", state_dbg, S_IDLE);
        chk("async_loss", link_loss_cnt, 0);
        chk("async_gen", link_gen, 2);
        model_reset();
        tick();
        rst_n = 1;

        // Offline hold, then simultaneous offline+COMRESET behaves as COMRESET.
        do_reset();
        gtx_ready = 1;
        wait_start(10, wn);
        tick();
        set_offline = 1; tick(); set_offline = 0;
        chk("offline_txidle", force_txelecidle, 1);
        starts = 0;
        for (int k = 0; k < 10; k++) begin tick(); if (oob_start === 1'b1) starts++; end
        chk("offline_no_start", starts, 0);
        set_offline = 1; comreset_send = 1; tick(); set_offline = 0; comreset_send = 0;
        chk("both_is_comreset", state_dbg, S_IDLE);
        tick();
        chk("comreset_start_2cyc", oob_start, 1);

        // Randomized traffic against the model.
        do_reset();
        for (int k = 0; k < 3000; k++) begin
            gtx_ready       = ($urandom_range(0, 99) < 96);
            set_offline     = ($urandom_range(0, 99) < 2);
            comreset_send   = ($urandom_range(0, 99) < 3);
            oob_busy        = ($urandom_range(0, 99) < 20);
            link_up         = ($urandom_range(0, 99) < 8);
            link_down       = ($urandom_range(0, 99) < 6);
            oob_error       = ($urandom_range(0, 99) < 10);
            oob_silence     = ($urandom_range(0, 99) < 10);
            cominit_req     = ($urandom_range(0, 99) < 5);
            rxbyteisaligned = ($urandom_range(0, 99) < 70);
            rate_ack        = ($urandom_range(0, 99) < 20);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
